multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Next-generation control unit for the micro ARM core, targeting a multicycle datapath with one shared instruction/data memory.
- A Moore-style FSM sequences fetch, decode, execute, memory and writeback, with stalls on a memory-ready handshake.
- Holds the NZCV flag register internally and evaluates conditions against it.
- Adds CMP, optional EOR and a parametrised ALU control width.

Parameters:
- ALU_CTRL_W, 2: alu_ctrl width. 2 = ADD/SUB/AND/ORR. 3 also enables EOR.
- MEM_WAIT_EN, 1: 1 = FETCH/MEMRD/MEMWR stall until mem_ready. 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cond  in  4  instr[31:28]
- op  in  2  instr[27:26]: 00 DP, 01 MEM, 10 B, 11 undefined
- funct  in  6  instr[25:20]: [5] I, [4:1] cmd, [0] S or L
- rd  in  4  instr[15:12]
- alu_flags  in  4  raw {N,Z,C,V} from the ALU, current cycle
- mem_ready  in  1  memory access completes this cycle
- pc_we  out  1  PC write enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_we  out  1  memory write enable
- ir_we  out  1  instruction register write enable
- reg_we  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  00 register A, 01 PC
- alu_src_b  out  2  00 register B, 01 ExtImm, 10 constant 4
- alu_ctrl  out  ALU_CTRL_W  ADD 0, SUB 1, AND 2, ORR 3, EOR 4 (zero-extended)
- imm_src  out  2  equals op in every state
- reg_src  out  2  {op==MEM & L==0, op==B}
- flags  out  4  registered {N,Z,C,V}
- instr_done  out  1  high on the final cycle of each instruction, including skipped instructions

Behaviour:
- Reset: state = FETCH, flags = 0.
  - While rst_n is low, all enables (pc_we, mem_we, ir_we, reg_we, instr_done) are forced to 0 and all selects to 0.
- Default in every state: enables 0, selects 0, alu_ctrl ADD.
- cond_ex is evaluated against the registered flags using the ARM table (EQ…LE, AL=1110). cond=1111 gives cond_ex=0.
- FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, ADD, result_src=10.
  - ir_we = pc_we = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alu_src_a=01, alu_src_b=10, ADD (produces PC+8). Next state:
  - cond_ex=0 → FETCH, with instr_done=1.
  - op=11, or DP with an unsupported cmd → FETCH, with instr_done=1.
  - MEM → MEMADR.
  - DP with I=0 → EXECR; DP with I=1 → EXECI.
  - B → BRANCH.
- EXECR: alu_src_b=00, alu_ctrl from the decoder → ALUWB.
- EXECI: alu_src_b=01, alu_ctrl from the decoder → ALUWB.
- ALU decoder (cmd → alu_ctrl):
  - 0100 ADD; 0010 SUB; 0000 AND; 1100 ORR.
  - 1010 CMP → SUB.
  - 0001 EOR → 4, only when ALU_CTRL_W≥3; otherwise unsupported.
- ALUWB: result_src=00, alu_ctrl held; reg_we=1 except for CMP.
  - pc_we=1 if rd==15 and reg_we=1.
  - instr_done=1; next state FETCH.
- Flag update, on the clock edge leaving EXECR/EXECI:
  - Only when S=1, or always for CMP.
  - N and Z are taken from alu_flags.
  - C and V are updated only for ADD/SUB/CMP; logical ops keep C and V.
- MEMADR: alu_src_b=01, ADD. Next state MEMRD if L=1, else MEMWR.
- MEMRD: adr_src=1; stay while mem_ready=0, then → MEMWB.
- MEMWB: result_src=01, reg_we=1, pc_we=(rd==15), instr_done=1 → FETCH.
- MEMWR: adr_src=1, mem_we=1, held for the whole stall. instr_done=mem_ready; → FETCH when mem_ready=1.
- BRANCH: alu_src_b=01, ADD, result_src=10, pc_we=1, instr_done=1 → FETCH.
- Reset asserted mid-instruction aborts it: no partial writes, flags cleared, restart at FETCH.
- Write enables depend only on state, decode and mem_ready. There are no combinational paths from alu_flags to any enable.

Test Plan:
1. Reset, then ADD R1,R2,#5 (op=00, funct=101000, cond=1110) with mem_ready=1 → states FETCH, DECODE, EXECI, ALUWB. alu_ctrl=0, reg_we=1 only in ALUWB, instr_done on cycle 4, flags unchanged.
2. SUBS with alu_flags=0110 → flags=0110 after EXECI. A following ADDEQ executes (4 cycles); a following ADDNE exits at DECODE with instr_done and never asserts reg_we.
3. LDR with mem_ready low for 3 cycles in MEMRD → FETCH, DECODE, MEMADR, MEMRD×4, MEMWB. adr_src=1 throughout MEMRD; reg_we only in MEMWB.
4. STR with mem_ready low for 2 cycles → mem_we high for 3 cycles in MEMWR, reg_we never high, reg_src=10.
5. ANDS after CMP set C=1,V=1, with alu_flags=1000 → flags=1011. Then B → BRANCH with pc_we=1, reg_src=01.
6. ALU_CTRL_W=2: EOR is skipped at DECODE. ALU_CTRL_W=3: EOR takes 4 cycles with alu_ctrl=100. Assert rst_n low in MEMWR → mem_we=0 immediately, state FETCH, flags 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath signal bundle for the multicycle ARM core.
// The master modport is the control unit; the slave modport is the datapath side.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 2
);
    logic [3:0]            cond;
    logic [1:0]            op;
    logic [5:0]            funct;
    logic [3:0]            rd;
    logic [3:0]            alu_flags;
    logic                  mem_ready;

    logic                  pc_we;
    logic                  adr_src;
    logic                  mem_we;
    logic                  ir_we;
    logic                  reg_we;
    logic [1:0]            result_src;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            imm_src;
    logic [1:0]            reg_src;
    logic [3:0]            flags;
    logic                  instr_done;

    modport master (
        input  cond, op, funct, rd, alu_flags, mem_ready,
        output pc_we, adr_src, mem_we, ir_we, reg_we, result_src, alu_src_a,
               alu_src_b, alu_ctrl, imm_src, reg_src, flags, instr_done
    );

    modport slave (
        output cond, op, funct, rd, alu_flags, mem_ready,
        input  pc_we, adr_src, mem_we, ir_we, reg_we, result_src, alu_src_a,
               alu_src_b, alu_ctrl, imm_src, reg_src, flags, instr_done
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM control unit: Moore FSM for fetch/decode/execute/memory/writeback
// with memory-ready stalls, an internal NZCV register and condition evaluation.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 2,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic                       clk,
    input logic                       rst_n,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    state_t     state, state_nxt;
    logic [3:0] flags_q;
    logic [3:0] cmd;
    logic [2:0] dec_ctrl, ctrl;
    logic       cmd_ok, is_cmp, is_arith, cond_ex, ready;

    assign cmd       = bus.funct[4:1];
    assign is_cmp    = (cmd == CMD_CMP);
    assign is_arith  = (dec_ctrl == ALU_ADD) || (dec_ctrl == ALU_SUB);
    assign ready     = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    assign bus.flags = flags_q;

    // ALU decoder; EOR exists only when alu_ctrl is wide enough to encode it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec_ctrl = ALU_ADD;
        cmd_ok   = 1'b1;
        case (cmd)
            CMD_ADD:          dec_ctrl = ALU_ADD;
            CMD_SUB, CMD_CMP: dec_ctrl = ALU_SUB;
            CMD_AND:          dec_ctrl = ALU_AND;
            CMD_ORR:          dec_ctrl = ALU_ORR;
            CMD_EOR: begin
                if (ALU_CTRL_W >= 3) dec_ctrl = ALU_EOR;
                else                 cmd_ok   = 1'b0;
            end
            default:          cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        case (bus.cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c && !z;
            4'b1001: cond_ex = !c || z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = !z && (n == v);
            4'b1101: cond_ex = z || (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Flags latch on the edge leaving execute; logical ops leave C and V alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if ((state == S_EXECR || state == S_EXECI) && (bus.funct[0] || is_cmp)) begin
            flags_q[3:2] <= bus.alu_flags[3:2];
            if (is_arith) flags_q[1:0] <= bus.alu_flags[1:0];
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.pc_we      = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.ir_we      = 1'b0;
        bus.reg_we     = 1'b0;
        bus.instr_done = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        ctrl           = ALU_ADD;
        bus.imm_src    = bus.op;
        bus.reg_src    = {(bus.op == OP_MEM) && !bus.funct[0], bus.op == OP_B};

        case (state)
            S_FETCH: begin
                bus.alu_src_a  = 2'b01;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_we      = ready;
                bus.pc_we      = ready;
                if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                state_nxt     = S_FETCH;
                if (!cond_ex) begin
                    bus.instr_done = 1'b1;
                end else begin
                    case (bus.op)
                        OP_MEM:  state_nxt = S_MEMADR;
                        OP_B:    state_nxt = S_BRANCH;
                        OP_DP: begin
                            if (!cmd_ok)            bus.instr_done = 1'b1;
                            else if (bus.funct[5])  state_nxt = S_EXECI;
                            else                    state_nxt = S_EXECR;
                        end
                        default: bus.instr_done = 1'b1;
                    endcase
                end
            end
            S_EXECR: begin
                ctrl      = dec_ctrl;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_b = 2'b01;
                ctrl          = dec_ctrl;
                state_nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl           = dec_ctrl;
                bus.reg_we     = !is_cmp;
                bus.pc_we      = !is_cmp && (bus.rd == 4'hF);
                bus.instr_done = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_MEMADR: begin
                bus.alu_src_b = 2'b01;
                state_nxt     = bus.funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.adr_src = 1'b1;
                if (ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_we     = 1'b1;
                bus.pc_we      = (bus.rd == 4'hF);
                bus.instr_done = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_MEMWR: begin
                bus.adr_src    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.instr_done = ready;
                if (ready) state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_we      = 1'b1;
                bus.instr_done = 1'b1;
                state_nxt      = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Reset held low silences every enable and select at once, even mid-instruction.
        if (!rst_n) begin
            bus.pc_we      = 1'b0;
            bus.adr_src    = 1'b0;
            bus.mem_we     = 1'b0;
            bus.ir_we      = 1'b0;
            bus.reg_we     = 1'b0;
            bus.instr_done = 1'b0;
            bus.result_src = 2'b00;
            bus.alu_src_a  = 2'b00;
            bus.alu_src_b  = 2'b00;
            bus.imm_src    = 2'b00;
            bus.reg_src    = 2'b00;
            ctrl           = ALU_ADD;
        end
    end

    assign bus.alu_ctrl = ALU_CTRL_W'(ctrl);
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, randomized instructions
// against an instruction-level model, and hand sequences for EOR width and mid-write reset.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_CTRL_W(3)) bus3 ();
    multicycle_control_unit_if #(.ALU_CTRL_W(2)) bus2 ();

    assign bus3.cond = cond;  assign bus3.op = op;  assign bus3.funct = funct;
    assign bus3.rd = rd;      assign bus3.alu_flags = alu_flags;  assign bus3.mem_ready = mem_ready;
    assign bus2.cond = cond;  assign bus2.op = op;  assign bus2.funct = funct;
    assign bus2.rd = rd;      assign bus2.alu_flags = alu_flags;  assign bus2.mem_ready = mem_ready;

    multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_WAIT_EN(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.master));
    multicycle_control_unit #(.ALU_CTRL_W(2), .MEM_WAIT_EN(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master));

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] af;
        int         wf;   // fetch wait cycles
        int         wd;   // data access wait cycles
    } instr_t;

    typedef struct {
        int         cycles;
        int         reg_n;
        int         mem_n;
        int         pc_n;
        int         ir_n;
        int         adr_n;
        logic [3:0] flags;
        logic [2:0] alu;
        logic [1:0] reg_src;
    } result_t;

    typedef struct {
        instr_t  in;
        result_t exp;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                input logic [3:0] r, input logic [3:0] a, input int wf, input int wd,
                                input int cyc, input int rg, input int mm, input int pc, input int adr,
                                input logic [3:0] fl, input logic [2:0] alu, input logic [1:0] rs);
        vec_t v;
        v.in  = '{cond: c, op: o, funct: f, rd: r, af: a, wf: wf, wd: wd};
        v.exp = '{cycles: cyc, reg_n: rg, mem_n: mm, pc_n: pc, ir_n: 1, adr_n: adr,
                  flags: fl, alu: alu, reg_src: rs};
        return v;
    endfunction

    // ARM conditions come in pairs: odd codes are the negation of the even code below them.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cy;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cy && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !r : r;
    endfunction

    function automatic int alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b1010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b0001: return 4;
            default: return -1;
        endcase
    endfunction

    // Instruction-level expectations: cycle count, enable counts and resulting flags.
    function automatic result_t predict(input instr_t in, input logic [3:0] fl);
        result_t    e;
        logic [3:0] cmd;
        int         code;
        e = '{default: 0};
        e.flags   = fl;
        e.ir_n    = 1;
        e.pc_n    = 1;
        e.cycles  = in.wf + 1;
        e.reg_src = {(in.op == 2'b01) && !in.funct[0], in.op == 2'b10};
        cmd       = in.funct[4:1];
        if (!cond_holds(in.cond, fl) || in.op == 2'b11) begin
            e.cycles += 1;
        end else if (in.op == 2'b10) begin
            e.cycles += 2;
            e.pc_n   += 1;
        end else if (in.op == 2'b01) begin
            e.adr_n = in.wd + 1;
            if (in.funct[0]) begin
                e.cycles += in.wd + 4;
                e.reg_n   = 1;
                if (in.rd == 4'hF) e.pc_n += 1;
            end else begin
                e.cycles += in.wd + 3;
                e.mem_n   = in.wd + 1;
            end
        end else begin
            code = alu_code(cmd);
            if (code < 0) begin
                e.cycles += 1;
            end else begin
                e.cycles += 3;
                e.alu     = 3'(code);
                e.reg_n   = (cmd == 4'b1010) ? 0 : 1;
                if (e.reg_n == 1 && in.rd == 4'hF) e.pc_n += 1;
                if (in.funct[0] || cmd == 4'b1010) begin
                    e.flags[3:2] = in.af[3:2];
                    if (code <= 1) e.flags[1:0] = in.af[1:0];
                end
            end
        end
        return e;
    endfunction

    // Starts at posedge+1 with the DUT in FETCH; returns at posedge+1 after instr_done.
    task automatic run_instr(input instr_t in, output result_t m);
        int k;
        int acc;
        bit done;
        cond = in.cond; op = in.op; funct = in.funct; rd = in.rd; alu_flags = in.af;
        m    = '{default: 0};
        acc  = in.wf + 3;
        k    = 0;
        done = 1'b0;
        while (!done && k < 64) begin
            if (k < in.wf)                                         mem_ready = 1'b0;
            else if (k == in.wf)                                   mem_ready = 1'b1;
            else if (in.op == 2'b01 && k >= acc && k < acc + in.wd) mem_ready = 1'b0;
            else if (in.op == 2'b01 && k == acc + in.wd)           mem_ready = 1'b1;
            else                                                   mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            m.reg_n += int'(bus3.reg_we);
            m.mem_n += int'(bus3.mem_we);
            m.pc_n  += int'(bus3.pc_we);
            m.ir_n  += int'(bus3.ir_we);
            m.adr_n += int'(bus3.adr_src);
            if (bus3.instr_done) begin
                done      = 1'b1;
                m.cycles  = k + 1;
                m.alu     = bus3.alu_ctrl;
                m.reg_src = bus3.reg_src;
            end
            @(posedge clk);
            #1;
            k++;
        end
        m.flags = bus3.flags;
        check("instr_done_within_bound", int'(done), 1);
    endtask

    task automatic compare_res(input string t, input result_t a, input result_t e);
        check({t, ".cycles"},  a.cycles, e.cycles);
        check({t, ".reg_we"},  a.reg_n,  e.reg_n);
        check({t, ".mem_we"},  a.mem_n,  e.mem_n);
        check({t, ".pc_we"},   a.pc_n,   e.pc_n);
        check({t, ".ir_we"},   a.ir_n,   e.ir_n);
        check({t, ".adr_src"}, a.adr_n,  e.adr_n);
        check({t, ".flags"},   int'(a.flags),   int'(e.flags));
        check({t, ".alu_ctrl"}, int'(a.alu),    int'(e.alu));
        check({t, ".reg_src"}, int'(a.reg_src), int'(e.reg_src));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t       tbl[16];
    logic [3:0] mflags;

    initial begin
        instr_t  in;
        result_t e, m;
        logic [3:0] cmd;
        int d2, d3, reg2, alu3;

        //            cond   op     funct      rd     af     wf wd cyc rg mm pc adr flags  alu   rs
        tbl[0]  = mk(4'hE, 2'b00, 6'b101000, 4'd1, 4'h0, 0, 0, 4, 1, 0, 1, 0, 4'b0000, 3'd0, 2'b00); // ADD #imm
        tbl[1]  = mk(4'hE, 2'b00, 6'b100101, 4'd3, 4'h6, 0, 0, 4, 1, 0, 1, 0, 4'b0110, 3'd1, 2'b00); // SUBS
        tbl[2]  = mk(4'h0, 2'b00, 6'b101000, 4'd4, 4'h9, 0, 0, 4, 1, 0, 1, 0, 4'b0110, 3'd0, 2'b00); // ADDEQ runs
        tbl[3]  = mk(4'h1, 2'b00, 6'b101000, 4'd4, 4'h9, 0, 0, 2, 0, 0, 1, 0, 4'b0110, 3'd0, 2'b00); // ADDNE skipped
        tbl[4]  = mk(4'hE, 2'b01, 6'b011001, 4'd5, 4'h0, 1, 3, 9, 1, 0, 1, 4, 4'b0110, 3'd0, 2'b00); // LDR, waits
        tbl[5]  = mk(4'hE, 2'b01, 6'b011000, 4'd6, 4'h0, 0, 2, 6, 0, 3, 1, 3, 4'b0110, 3'd0, 2'b10); // STR, waits
        tbl[6]  = mk(4'hE, 2'b00, 6'b110101, 4'd0, 4'h3, 0, 0, 4, 0, 0, 1, 0, 4'b0011, 3'd1, 2'b00); // CMP
        tbl[7]  = mk(4'hE, 2'b00, 6'b000001, 4'd7, 4'h8, 0, 0, 4, 1, 0, 1, 0, 4'b1011, 3'd2, 2'b00); // ANDS keeps CV
        tbl[8]  = mk(4'hE, 2'b10, 6'b100000, 4'd0, 4'h0, 0, 0, 3, 0, 0, 2, 0, 4'b1011, 3'd0, 2'b01); // B
        tbl[9]  = mk(4'hE, 2'b00, 6'b011000, 4'hF, 4'h0, 0, 0, 4, 1, 0, 2, 0, 4'b1011, 3'd3, 2'b00); // ORR to PC
        tbl[10] = mk(4'hE, 2'b11, 6'b000000, 4'd1, 4'h0, 0, 0, 2, 0, 0, 1, 0, 4'b1011, 3'd0, 2'b00); // op=11
        tbl[11] = mk(4'hF, 2'b00, 6'b101000, 4'd1, 4'h0, 0, 0, 2, 0, 0, 1, 0, 4'b1011, 3'd0, 2'b00); // cond=1111
        tbl[12] = mk(4'hE, 2'b00, 6'b000110, 4'd1, 4'h0, 2, 0, 4, 0, 0, 1, 0, 4'b1011, 3'd0, 2'b00); // bad cmd
        tbl[13] = mk(4'hE, 2'b01, 6'b011001, 4'hF, 4'h0, 0, 0, 5, 1, 0, 2, 1, 4'b1011, 3'd0, 2'b00); // LDR PC
        tbl[14] = mk(4'hB, 2'b00, 6'b101000, 4'd1, 4'h0, 0, 0, 2, 0, 0, 1, 0, 4'b1011, 3'd0, 2'b00); // LT fails
        tbl[15] = mk(4'hE, 2'b00, 6'b000011, 4'd2, 4'h4, 0, 0, 4, 1, 0, 1, 0, 4'b0111, 3'd4, 2'b00); // EORS

        rst_n = 1'b0; mem_ready = 1'b1;
        cond = 4'hE; op = 2'b00; funct = 6'b101000; rd = 4'd1; alu_flags = 4'hF;
        #3;
        check("rst.ir_we",      int'(bus3.ir_we), 0);
        check("rst.pc_we",      int'(bus3.pc_we), 0);
        check("rst.enables",    int'({bus3.reg_we, bus3.mem_we, bus3.instr_done}), 0);
        check("rst.selects",    int'({bus3.adr_src, bus3.alu_src_a, bus3.alu_src_b, bus3.result_src}), 0);
        check("rst.flags",      int'(bus3.flags), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst.fetch_ir_we", int'(bus3.ir_we), 1);
        check("post_rst.fetch_src_b", int'(bus3.alu_src_b), 2);

        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i].in, m);
            compare_res($sformatf("vec%0d", i), m, tbl[i].exp);
        end
        mflags = tbl[15].exp.flags;

        for (int n = 0; n < 200; n++) begin
            in.cond = $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15));
            in.op   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0:       cmd = 4'b0100;
                1:       cmd = 4'b0010;
                2:       cmd = 4'b0000;
                3:       cmd = 4'b1100;
                4:       cmd = 4'b1010;
                5:       cmd = 4'b0001;
                default: cmd = 4'($urandom_range(0, 15));
            endcase
            in.funct = {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))};
            in.rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            in.af    = 4'($urandom_range(0, 15));
            in.wf    = $urandom_range(0, 2);
            in.wd    = $urandom_range(0, 3);
            e = predict(in, mflags);
            run_instr(in, m);
            compare_res($sformatf("rand%0d", n), m, e);
            mflags = e.flags;
        end

        // EOR is unsupported at width 2 and a 4-cycle ALU op at width 3.
        do_reset();
        cond = 4'hE; op = 2'b00; funct = 6'b000010; rd = 4'd3; alu_flags = 4'h0; mem_ready = 1'b1;
        d2 = -1; d3 = -1; reg2 = 0; alu3 = -1;
        for (int k = 0; k < 8 && d3 < 0; k++) begin
            @(negedge clk);
            if (d2 < 0) reg2 += int'(bus2.reg_we);
            if (d2 < 0 && bus2.instr_done) d2 = k;
            if (bus3.instr_done) begin
                d3   = k;
                alu3 = int'(bus3.alu_ctrl);
            end
            @(posedge clk);
            #1;
        end
        check("eor_w2.done_cycle", d2, 1);
        check("eor_w2.reg_we",     reg2, 0);
        check("eor_w3.done_cycle", d3, 3);
        check("eor_w3.alu_ctrl",   alu3, 4);

        // Reset in the middle of a stalled store.
        in = '{cond: 4'hE, op: 2'b00, funct: 6'b100101, rd: 4'd1, af: 4'hF, wf: 0, wd: 0};
        e  = predict(in, 4'b0000);
        run_instr(in, m);
        compare_res("subs_pre", m, e);
        cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'd2; mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        #1;
        check("memwr.mem_we", int'(bus3.mem_we), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort.mem_we", int'(bus3.mem_we), 0);
        check("abort.flags",  int'(bus3.flags), 0);
        mem_ready = 1'b1;
        #1;
        check("abort.ir_we_forced", int'(bus3.ir_we), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("restart.ir_we",   int'(bus3.ir_we), 1);
        check("restart.adr_src", int'(bus3.adr_src), 0);
        in = '{cond: 4'hE, op: 2'b00, funct: 6'b101000, rd: 4'd1, af: 4'h5, wf: 0, wd: 0};
        e  = predict(in, 4'b0000);
        run_instr(in, m);
        compare_res("restart_add", m, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
